// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked pipelined adder.
// Holds the configuration check and the saturation constant helper.
package adder_pkg;

    // Per-stage control flags carried alongside the chunk data.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_flags_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width)
            && ((width % stages) == 0);
    endfunction

    // One bit of the signed max (neg=0) or signed min (neg=1) constant.
    function automatic logic sat_bit(input logic neg, input logic is_msb);
        return is_msb ? neg : ~neg;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Stream handshake bundle for the pipelined adder.
// Operand side and result side share one interface.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/adder_stage.sv
// One CW-bit ripple chunk of the pipelined adder with its registers.
// PIPELINED_ADDER_SATURATE_EN adds the clamp in the last stage.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 8,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cin,
    output logic             valid_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q
);
    localparam int LO = IDX * CW;

    stage_flags_t     flags_q;
    logic [WIDTH-1:0] sum_d;
    logic             c;
    logic             ovf_d;

    always_comb begin
        sum_d = sum_in;
        c     = cin;
        for (int i = 0; i < CW; i++) begin
            sum_d[LO+i] = a[LO+i] ^ b[LO+i] ^ c;
            c = (a[LO+i] & b[LO+i]) | (c & (a[LO+i] ^ b[LO+i]));
        end
        ovf_d = LAST && (a[WIDTH-1] == b[WIDTH-1])
             && (sum_d[WIDTH-1] != a[WIDTH-1]);
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (ovf_d) begin
            for (int i = 0; i < WIDTH; i++) begin
                sum_d[i] = sat_bit(a[WIDTH-1], i == WIDTH - 1);
            end
        end
`endif
    end

    // Data only moves with a valid beat; empty stages keep stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (load) begin
            flags_q.valid <= valid_in;
            if (valid_in) begin
                a_q           <= a;
                b_q           <= b;
                sum_q         <= sum_d;
                flags_q.carry <= c;
                flags_q.ovf   <= ovf_d;
            end
        end
    end

    assign valid_q = flags_q.valid;
    assign carry_q = flags_q.carry;
    assign ovf_q   = flags_q.ovf;

endmodule

// File: rtl/pipelined_adder.sv
// Streaming adder: carry chain split into STAGES registered chunks.
// Optional clamp on signed overflow: PIPELINED_ADDER_SATURATE_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave io
);
    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipelined_adder: WIDTH/STAGES invalid");
    end

    logic [STAGES-1:0] valid_w;
    logic [STAGES:0]   load;
    logic [WIDTH-1:0]  a_w   [STAGES];
    logic [WIDTH-1:0]  b_w   [STAGES];
    logic [WIDTH-1:0]  sum_w [STAGES];
    logic              carry_w [STAGES];
    logic              ovf_w   [STAGES];
    logic              unused_ops;

    // A stage advances when empty or when its successor advances.
    always_comb begin
        load         = '0;
        load[STAGES] = io.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !valid_w[k] || load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             v_i;
        logic             c_i;

        if (k == 0) begin : g_first
            assign a_i = io.in_a;
            assign b_i = io.in_b;
            assign s_i = '0;
            assign v_i = io.in_valid;
            assign c_i = io.in_cin;
        end else begin : g_next
            assign a_i = a_w[k-1];
            assign b_i = b_w[k-1];
            assign s_i = sum_w[k-1];
            assign v_i = valid_w[k-1];
            assign c_i = carry_w[k-1];
        end

        adder_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .valid_in (v_i),
            .a        (a_i),
            .b        (b_i),
            .sum_in   (s_i),
            .cin      (c_i),
            .valid_q  (valid_w[k]),
            .a_q      (a_w[k]),
            .b_q      (b_w[k]),
            .sum_q    (sum_w[k]),
            .carry_q  (carry_w[k]),
            .ovf_q    (ovf_w[k])
        );
    end

    assign io.in_ready  = rst_n && load[0];
    assign io.out_valid = rst_n && valid_w[STAGES-1];
    assign io.out_sum   = sum_w[STAGES-1];
    assign io.out_cout  = carry_w[STAGES-1];
    assign io.out_ovf   = ovf_w[STAGES-1];

    assign unused_ops = ^{a_w[STAGES-1], b_w[STAGES-1]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8, STAGES=2.
// Expectations follow PIPELINED_ADDER_SATURATE_EN when it is defined.
module tb_pipelined_adder;
    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int occ      = 0;
    logic [W+1:0] sb_q [$];
    int           acc_q [$];
    bit           lat_mode   = 1'b0;
    bit           in_fire_s  = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W+1:0] prev_out;
    logic [W+1:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0]   t;
        logic [W-1:0] s;
        logic         ovf;
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s   = t[W-1:0];
        ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (ovf) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {ovf, t[W], s};
    endfunction

    task automatic step();
        logic [W+1:0] cur;
        logic [W+1:0] e;
        int           a0;
        @(negedge clk);
        cur = {bus.out_ovf, bus.out_cout, bus.out_sum};
        in_fire_s = 1'b0;
        if (!rst_n) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
            prev_stall = 1'b0;
        end else begin
            check("in_ready", bus.in_ready, !(occ == S && !bus.out_ready));
            if (prev_stall)
                check("stall_hold", {bus.out_valid, cur}, {1'b1, prev_out});
            in_fire_s = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e  = sb_q.pop_front();
                    a0 = acc_q.pop_front();
                    check("result", cur, e);
                    if (lat_mode) check("latency", cyc - a0, S);
                    occ--;
                end
                last_out = cur;
            end
            if (in_fire_s) begin
                sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin));
                acc_q.push_back(cyc);
                occ++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = cur;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_dir(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin,
                            input logic [W+1:0] exp);
        int n;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!in_fire_s && n < 20);
        bus.in_valid = 1'b0;
        check({tag, "_acc"}, in_fire_s, 1);
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_drain"}, sb_q.size(), 0);
        check(tag, last_out, exp);
    endtask

    initial begin
        int n;
        int fired;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) step();
        rst_n = 1'b1;
        #3;
        check("rst_out_valid_after", bus.out_valid, 0);
        check("rst_sum", bus.out_sum, 0);
        check("rst_cout", bus.out_cout, 0);
        check("rst_ovf", bus.out_ovf, 0);

        bus.out_ready = 1'b1;
        lat_mode = 1'b1;
        send_dir("ff_01", 8'hFF, 8'h01, 1'b0, 10'h100);
`ifdef PIPELINED_ADDER_SATURATE_EN
        send_dir("7f_01", 8'h7F, 8'h01, 1'b0, 10'h27F);
        send_dir("80_ff", 8'h80, 8'hFF, 1'b0, 10'h380);
`else
        send_dir("7f_01", 8'h7F, 8'h01, 1'b0, 10'h280);
        send_dir("80_ff", 8'h80, 8'hFF, 1'b0, 10'h37F);
`endif
        send_dir("ff_00_c", 8'hFF, 8'h00, 1'b1, 10'h100);
        send_dir("c0_c0", 8'hC0, 8'hC0, 1'b0, 10'h180);
        send_dir("55_22_c", 8'h55, 8'h22, 1'b1, 10'h078);

        for (int i = 0; i < 100; i++) begin
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
            bus.in_cin   = 1'($urandom);
            bus.in_valid = 1'b1;
            step();
            check("stream_acc", in_fire_s, 1);
        end
        bus.in_valid = 1'b0;
        repeat (S + 2) step();
        check("stream_drain", sb_q.size(), 0);
        lat_mode = 1'b0;

        in_fire_s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid || in_fire_s) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
                bus.in_cin   = 1'($urandom);
            end
            bus.out_ready = 1'($urandom);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("bp_drain", sb_q.size(), 0);

        bus.out_ready = 1'b0;
        bus.in_a      = 8'h12;
        bus.in_b      = 8'h34;
        bus.in_cin    = 1'b0;
        bus.in_valid  = 1'b1;
        fired = 0;
        n = 0;
        while (fired < 2 && n < 20) begin
            step();
            if (in_fire_s) begin
                fired++;
                bus.in_a = 8'h56;
            end
            n++;
        end
        bus.in_valid = 1'b0;
        check("mid_fill", fired, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb_q.delete();
        acc_q.delete();
        occ = 0;
        prev_stall = 1'b0;
        #3;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.out_sum, 0);
        check("mid_rst_cout", bus.out_cout, 0);
        bus.out_ready = 1'b1;
        repeat (6) step();
        lat_mode = 1'b1;
        send_dir("post_rst", 8'h0F, 8'h01, 1'b0, 10'h010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
